spi_master11: RTL and testbench

Single-register SPI read master for an MPU-style inertial sensor. On a start request it shifts an 8-bit address/command byte out on MOSI, then clocks in one 8-bit data byte from MISO and presents it with a one-cycle finish strobe. It sits between the sensor-polling logic and the external SPI pins. Chip select is driven externally, qualified by `busy`.

---
 rtl/spi_master11.sv | 105 ++++++++++
 tb/tb_spi_master11.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master11.sv
// Single-register SPI read master (mode 3): shifts out one command byte, then captures
// one data byte from MISO and presents it with a single-cycle finish strobe.
module spi_master11 #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       miso_i,
    input  logic [7:0] addr_i,
    output logic       sclk_o,
    output logic       busy_o,
    output logic       finish_o,
    output logic       mosi_o,
    output logic [7:0] data_o
);

    localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [3:0]      bit_q;
    logic [6:0]      tx_q;
    logic [6:0]      rx_q;
    logic            sclk_q;
    logic            mosi_q;
    logic            busy_q;
    logic            finish_q;
    logic [7:0]      data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            finish_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sclk_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (start_i) begin
                        state_q <= StXfer;
                        busy_q  <= 1'b1;
                        tx_q    <= addr_i[6:0];
                        mosi_q  <= addr_i[7];
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                StXfer: begin
                    if (div_q == DivMax) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            // Falling edge: bit 0 was already presented on entry.
                            if (bit_q != 4'd0) begin
                                mosi_q <= tx_q[6];
                                tx_q   <= {tx_q[5:0], 1'b0};
                            end
                        end else begin
                            rx_q <= {rx_q[5:0], miso_i};
                            if (bit_q == 4'd15) begin
                                state_q  <= StDone;
                                busy_q   <= 1'b0;
                                finish_q <= 1'b1;
                                mosi_q   <= 1'b0;
                                data_q   <= {rx_q, miso_i};
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    sclk_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sclk_o   = sclk_q;
    assign mosi_o   = mosi_q;
    assign busy_o   = busy_q;
    assign finish_o = finish_q;
    assign data_o   = data_q;

endmodule

// File: tb/tb_spi_master11.sv
// Directed bench for spi_master11 with CLK_DIV=4; all sampling on the falling clk edge.
module tb_spi_master11;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       miso;
    logic [7:0] addr;
    logic       sclk;
    logic       busy;
    logic       finish;
    logic       mosi;
    logic [7:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_busy, m_rises, m_falls, m_fin, m_fin_at, m_fin_busy, m_pre_bad, m_ofs;
    logic [15:0] m_mosi;
    logic [7:0]  m_data;

    spi_master11 #(.CLK_DIV(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .miso_i   (miso),
        .addr_i   (addr),
        .sclk_o   (sclk),
        .busy_o   (busy),
        .finish_o (finish),
        .mosi_o   (mosi),
        .data_o   (data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Runs one request from a negedge and records what the pins did over ncyc cycles.
    task automatic xfer(input logic [7:0] a, input logic [7:0] mb, input int start_len,
                        input int pulse_at, input int ncyc, input logic [7:0] hold);
        int   brise;
        int   ffall;
        logic ps;
        logic pb;
        brise = -1; ffall = -1;
        m_busy = 0; m_rises = 0; m_falls = 0; m_fin = 0; m_fin_at = -1;
        m_fin_busy = 0; m_pre_bad = 0; m_mosi = '0; m_data = '0;
        addr = a; start = 1'b1; miso = 1'b1;
        ps = sclk; pb = busy;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) addr = ~a;
            if (pulse_at >= 0 && c >= pulse_at && c < pulse_at + 2) start = 1'b1;
            else if (c + 1 >= start_len) start = 1'b0;
            if (busy) m_busy++;
            if (busy && !pb && brise < 0) brise = c;
            if (sclk && !ps) begin
                if (m_rises < 16) m_mosi[15 - m_rises] = mosi;
                m_rises++;
            end
            if (!sclk && ps) begin
                if (ffall < 0) ffall = c;
                miso = (m_falls >= 8 && m_falls < 16) ? mb[15 - m_falls] : 1'b1;
                m_falls++;
            end
            if (finish) begin
                m_fin++;
                if (m_fin_at < 0) m_fin_at = c;
                m_data = data;
                if (busy) m_fin_busy++;
            end else if (m_fin == 0 && data !== hold) begin
                m_pre_bad++;
            end
            ps = sclk; pb = busy;
        end
        start = 1'b0; miso = 1'b1;
        m_ofs = ffall - brise;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({sclk, mosi, busy, finish, data} !== 12'h800) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h",
                         {sclk, mosi, busy, finish, data}, 12'h800);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_high();
        xfer(8'hB7, 8'hFF, 3, -1, 160, 8'h00);
        n_checks++;
        if (m_busy !== 128) begin n_fail++; $display("FAIL r1_busy_cycles: got %0d expected 128", m_busy); end
        n_checks++;
        if (m_rises !== 16) begin n_fail++; $display("FAIL r1_rises: got %0d expected 16", m_rises); end
        n_checks++;
        if (m_falls !== 16) begin n_fail++; $display("FAIL r1_falls: got %0d expected 16", m_falls); end
        n_checks++;
        if (m_mosi !== 16'hB700) begin n_fail++; $display("FAIL r1_mosi: got %h expected b700", m_mosi); end
        n_checks++;
        if (m_fin !== 1) begin n_fail++; $display("FAIL r1_finish_count: got %0d expected 1", m_fin); end
        n_checks++;
        if (m_data !== 8'hFF) begin n_fail++; $display("FAIL r1_data: got %h expected ff", m_data); end
        n_checks++;
        if (m_ofs !== 4) begin n_fail++; $display("FAIL r1_first_fall: got %0d expected 4", m_ofs); end
        n_checks++;
        if (m_fin_busy !== 0) begin n_fail++; $display("FAIL r1_finish_busy: got %0d expected 0", m_fin_busy); end
    endtask

    task automatic test_second_read();
        xfer(8'hED, 8'h5A, 1, -1, 160, 8'hFF);
        n_checks++;
        if (m_mosi !== 16'hED00) begin n_fail++; $display("FAIL r2_mosi: got %h expected ed00", m_mosi); end
        n_checks++;
        if (m_data !== 8'h5A) begin n_fail++; $display("FAIL r2_data: got %h expected 5a", m_data); end
        n_checks++;
        if (m_pre_bad !== 0) begin n_fail++; $display("FAIL r2_data_hold: got %0d expected 0", m_pre_bad); end
        n_checks++;
        if (m_fin_at !== 128) begin n_fail++; $display("FAIL r2_finish_cycle: got %0d expected 128", m_fin_at); end
    endtask

    task automatic test_start_while_busy();
        xfer(8'h3C, 8'hC3, 1, 50, 160, 8'h5A);
        n_checks++;
        if (m_rises !== 16) begin n_fail++; $display("FAIL swb_rises: got %0d expected 16", m_rises); end
        n_checks++;
        if (m_fin_at !== 128) begin n_fail++; $display("FAIL swb_finish_cycle: got %0d expected 128", m_fin_at); end
        n_checks++;
        if (m_fin !== 1) begin n_fail++; $display("FAIL swb_finish_count: got %0d expected 1", m_fin); end
        n_checks++;
        if (m_busy !== 128) begin n_fail++; $display("FAIL swb_busy_cycles: got %0d expected 128", m_busy); end
        n_checks++;
        if (m_data !== 8'hC3) begin n_fail++; $display("FAIL swb_data: got %h expected c3", m_data); end
        n_checks++;
        if (m_mosi !== 16'h3C00) begin n_fail++; $display("FAIL swb_mosi: got %h expected 3c00", m_mosi); end
    endtask

    task automatic test_reset_mid();
        int   rises = 0;
        int   fins  = 0;
        logic found = 1'b0;
        logic ps;
        addr = 8'hA5; start = 1'b1; ps = sclk;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (sclk && !ps) rises++;
            if (rises == 6) found = 1'b1;
            ps = sclk;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rm_reach_bit5: got %0d rises expected 6", rises); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sclk, mosi, busy, finish, data} !== 12'h800) begin
            n_fail++;
            $display("FAIL rm_async_reset: got %h expected %h", {sclk, mosi, busy, finish, data}, 12'h800);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (finish) fins++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (finish) fins++;
        end
        n_checks++;
        if (fins !== 0) begin n_fail++; $display("FAIL rm_no_finish: got %0d expected 0", fins); end
        xfer(8'h96, 8'h3C, 1, -1, 160, 8'h00);
        n_checks++;
        if (m_rises !== 16) begin n_fail++; $display("FAIL rm_after_rises: got %0d expected 16", m_rises); end
        n_checks++;
        if (m_busy !== 128) begin n_fail++; $display("FAIL rm_after_busy: got %0d expected 128", m_busy); end
        n_checks++;
        if (m_data !== 8'h3C) begin n_fail++; $display("FAIL rm_after_data: got %h expected 3c", m_data); end
        n_checks++;
        if (m_mosi !== 16'h9600) begin n_fail++; $display("FAIL rm_after_mosi: got %h expected 9600", m_mosi); end
    endtask

    task automatic test_back_to_back();
        int   r[$];
        int   f[$];
        logic pb;
        addr = 8'h81; miso = 1'b1; start = 1'b1; pb = busy;
        for (int c = 0; c < 259; c++) begin
            @(negedge clk);
            if (busy && !pb) r.push_back(c);
            if (finish) f.push_back(c);
            pb = busy;
        end
        start = 1'b0;
        n_checks++;
        if (r.size() !== 2) begin n_fail++; $display("FAIL b2b_busy_rises: got %0d expected 2", r.size()); end
        n_checks++;
        if (f.size() !== 2) begin n_fail++; $display("FAIL b2b_finish_count: got %0d expected 2", f.size()); end
        if (r.size() >= 2 && f.size() >= 1) begin
            n_checks++;
            if (r[1] - f[0] !== 2) begin
                n_fail++;
                $display("FAIL b2b_idle_gap: got %0d expected 2", r[1] - f[0]);
            end
        end
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stops: got %b expected 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; miso = 1'b1; addr = 8'h00;
        test_reset();
        test_read_high();
        test_second_read();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
